// File: rtl/uart_rx.sv
// Memory-mapped 8N1 UART receiver: oversampled start/data/stop detection feeding a
// small byte FIFO that the CPU drains through RXDATA, with sticky error flags in STATUS.
module uart_rx #(
  parameter int CLK_FREQ   = 100000000,
  parameter int BAUD_RATE  = 115200,
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  addr,
  input  logic        we,
  input  logic        re,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        rx,
  output logic        irq
);

  localparam int TICK_DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = $clog2(OVERSAMPLE);
  localparam int PW       = $clog2(FIFO_DEPTH);
  localparam int CW       = PW + 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SC_HALF   = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SC_LAST   = SW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_e;

  logic          rx_meta_q, rx_s_q;
  logic [TW-1:0] tick_cnt_q;
  logic          tick;
  state_e        state_q;
  logic [SW-1:0] sc_q;
  logic [2:0]    bit_q;
  logic [7:0]    shift_q;
  logic          push_q, ferr_set_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          overrun_q, overrun_d, frame_err_q, frame_err_d;
  logic          full, empty, pop, wr_en, status_wr;
  logic          unused_wdata;

  // NOTE: every clocked process uses non-blocking (<=) so all registers update from
  // pre-edge values; blocking assignments here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta_q  <= 1'b1;
      rx_s_q     <= 1'b1;
      tick_cnt_q <= '0;
    end else begin
      rx_meta_q  <= rx;
      rx_s_q     <= rx_meta_q;
      tick_cnt_q <= (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    end
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      sc_q       <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      ferr_set_q <= 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: if (!rx_s_q) begin
            state_q <= S_START;
            sc_q    <= '0;
          end
          // Mid-start re-check rejects short low glitches without flagging anything.
          S_START: if (sc_q == SC_HALF) begin
            sc_q    <= '0;
            bit_q   <= '0;
            state_q <= rx_s_q ? S_IDLE : S_DATA;
          end else sc_q <= sc_q + SW'(1);
          S_DATA: if (sc_q == SC_LAST) begin
            sc_q    <= '0;
            shift_q <= {rx_s_q, shift_q[7:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'd7) state_q <= S_STOP;
          end else sc_q <= sc_q + SW'(1);
          S_STOP: if (sc_q == SC_LAST) begin
            sc_q <= '0;
            if (rx_s_q) begin
              push_q  <= 1'b1;
              state_q <= S_IDLE;
            end else begin
              ferr_set_q <= 1'b1;
              state_q    <= S_BREAK;
            end
          end else sc_q <= sc_q + SW'(1);
          S_BREAK: if (rx_s_q) state_q <= S_IDLE;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == CNT_FULL);
    pop       = re && (addr == 4'h0) && !empty;
    wr_en     = push_q && (!full || pop);
    status_wr = we && (addr == 4'h4);
    wr_ptr_d  = wr_en ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = pop ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (wr_en && !pop)      count_d = count_q + CW'(1);
    else if (!wr_en && pop) count_d = count_q - CW'(1);
    overrun_d   = (push_q && full && !pop) || (overrun_q && !(status_wr && wdata[1]));
    frame_err_d = ferr_set_q || (frame_err_q && !(status_wr && wdata[2]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= shift_q;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      4'h0:    if (!empty) rdata = {24'h0, mem[rd_ptr_q]};
      4'h4:    rdata = {28'h0, full, frame_err_q, overrun_q, !empty};
      default: rdata = '0;
    endcase
  end

  assign irq          = !empty;
  assign unused_wdata = ^{wdata[31:3], wdata[0]};

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: drives serial frames on rx and checks results through
// bus reads of RXDATA/STATUS plus irq, against hand-computed values.
module tb_uart_rx;

  // Scaled clock so one bit is 96 clocks (TICK_DIV = 6) and the run stays short.
  localparam int CLK_FREQ = 11059200;
  localparam int BIT      = 96;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  addr = '0;
  logic        we = 1'b0;
  logic        re = 1'b0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        rx = 1'b1;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;

  uart_rx #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(115200), .OVERSAMPLE(16), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst), .addr(addr), .we(we), .re(re),
    .wdata(wdata), .rdata(rdata), .rx(rx), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    addr = a;
    re   = 1'b1;
    #1 d = rdata;
    @(posedge clk);
    #1 re = 1'b0;
    addr = '0;
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    addr  = a;
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #1 we = 1'b0;
    addr  = '0;
    wdata = '0;
  endtask

  task automatic check_reg(input string tag, input logic [3:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    check(tag, d, exp);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    @(negedge clk);
    rx = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(negedge clk);
    end
    rx = stop;
    repeat (BIT) @(negedge clk);
    rx = 1'b1;
    repeat (BIT) @(negedge clk);
  endtask

  // Pops on exactly the clock where the received byte is written into the FIFO.
  task automatic aligned_pop(output logic found, output logic [31:0] d);
    found = 1'b0;
    d     = '0;
    for (int k = 0; k < 14 * BIT && !found; k++) begin
      @(negedge clk);
      if (dut.push_q) begin
        addr = 4'h0;
        re   = 1'b1;
        #1 d = rdata;
        @(posedge clk);
        #1 re = 1'b0;
        found = 1'b1;
      end
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        found;
    logic [31:0] d;

    repeat (4) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    check("rst_irq", {31'h0, irq}, 32'h0);
    check_reg("rst_status", 4'h4, 32'h0);
    check_reg("rst_rxdata", 4'h0, 32'h0);

    // 1: good frame 0xA5
    send_frame(8'hA5, 1'b1);
    check_reg("t1_status", 4'h4, 32'h1);
    check("t1_irq", {31'h0, irq}, 32'h1);
    check_reg("t1_unmapped", 4'h8, 32'h0);
    check_reg("t1_rxdata", 4'h0, 32'hA5);
    check_reg("t1_status_after", 4'h4, 32'h0);
    check("t1_irq_after", {31'h0, irq}, 32'h0);

    // 2: short low glitch rejected, then a real frame
    @(negedge clk);
    rx = 1'b0;
    repeat (18) @(negedge clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge clk);
    check_reg("t2_status", 4'h4, 32'h0);
    check("t2_idle", 32'(dut.state_q), 32'h0);
    send_frame(8'h3C, 1'b1);
    check_reg("t2_rxdata", 4'h0, 32'h3C);

    // 3: bad stop bit -> frame error, byte discarded, W1C clears it
    send_frame(8'h3C, 1'b0);
    check_reg("t3_status", 4'h4, 32'h4);
    check("t3_irq", {31'h0, irq}, 32'h0);
    bus_write(4'h4, 32'h4);
    check_reg("t3_status_clr", 4'h4, 32'h0);

    // 4: five frames into a four-entry FIFO -> overrun
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
    check_reg("t4_status", 4'h4, 32'hB);
    for (int i = 1; i <= 4; i++) check_reg($sformatf("t4_rd%0d", i), 4'h0, 32'(i));
    check_reg("t4_rd_empty", 4'h0, 32'h0);
    check_reg("t4_status_empty", 4'h4, 32'h2);
    bus_write(4'h4, 32'h2);
    check_reg("t4_status_clr", 4'h4, 32'h0);

    // 5: pop on the same clock as a push into a full FIFO
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    send_frame(8'h33, 1'b1);
    send_frame(8'h44, 1'b1);
    check_reg("t5_status_full", 4'h4, 32'h9);
    fork
      send_frame(8'h55, 1'b1);
      aligned_pop(found, d);
    join
    check("t5_aligned_found", {31'h0, found}, 32'h1);
    check("t5_aligned_data", d, 32'h11);
    check_reg("t5_status", 4'h4, 32'h9);
    check_reg("t5_rd1", 4'h0, 32'h22);
    check_reg("t5_rd2", 4'h0, 32'h33);
    check_reg("t5_rd3", 4'h0, 32'h44);
    check_reg("t5_rd4", 4'h0, 32'h55);

    // 6: reset in the middle of the data bits of 0xFF
    fork
      send_frame(8'hFF, 1'b1);
      begin
        repeat (3 * BIT) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    join
    check_reg("t6_status", 4'h4, 32'h0);
    check("t6_irq", {31'h0, irq}, 32'h0);
    send_frame(8'h7E, 1'b1);
    check_reg("t6_rxdata", 4'h0, 32'h7E);
    check_reg("t6_status_end", 4'h4, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
